// File: rtl/cdb_lane_arbiter_pkg.sv
// Shared parameter defaults and small index helpers for the multi-lane
// common-data-bus arbiter.
package cdb_lane_arbiter_pkg;

   localparam int DEF_WORD_SIZE = 32;
   localparam int DEF_RB_INDEX  = 4;
   localparam int DEF_FU_NUM    = 8;
   localparam int DEF_CDB_LANES = 2;

   // Distance of FU 'fu' after the round-robin pointer; 0 means highest priority.
   function automatic int rotate_pos(input int fu, input int ptr, input int fu_num);
      int pos;
      pos = fu - ptr;
      if (pos < 0) begin
         pos = pos + fu_num;
      end
      return pos;
   endfunction

   // Modulo-fu_num increment that works for non-power-of-two FU counts.
   function automatic int wrap_inc(input int idx, input int fu_num);
      return (idx + 1 >= fu_num) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/cdb_lane_arbiter_if.sv
// Result-bus bundle between the functional units and the CDB arbiter.
// The master side is the producer/consumer environment, the slave side
// is the arbiter itself.
interface cdb_lane_arbiter_if
   import cdb_lane_arbiter_pkg::*;
#(
   parameter int WORD_SIZE = DEF_WORD_SIZE,
   parameter int RB_INDEX  = DEF_RB_INDEX,
   parameter int FU_NUM    = DEF_FU_NUM,
   parameter int CDB_LANES = DEF_CDB_LANES
) ();

   localparam int FU_INDEX = $clog2(FU_NUM);

   logic [FU_NUM-1:0]             fu_valid;
   logic [FU_NUM-1:0]             fu_ready;
   logic [FU_NUM*WORD_SIZE-1:0]   fu_data;
   logic [FU_NUM*WORD_SIZE-1:0]   fu_addr;
   logic [FU_NUM*RB_INDEX-1:0]    fu_rb_index;

   logic [CDB_LANES-1:0]           cdb_valid;
   logic [CDB_LANES*WORD_SIZE-1:0] cdb_data;
   logic [CDB_LANES*WORD_SIZE-1:0] cdb_addr;
   logic [CDB_LANES*RB_INDEX-1:0]  cdb_rb_index;
   logic [CDB_LANES*FU_INDEX-1:0]  cdb_fu;

   modport master (
      output fu_valid,
      output fu_data,
      output fu_addr,
      output fu_rb_index,
      input  fu_ready,
      input  cdb_valid,
      input  cdb_data,
      input  cdb_addr,
      input  cdb_rb_index,
      input  cdb_fu
   );

   modport slave (
      input  fu_valid,
      input  fu_data,
      input  fu_addr,
      input  fu_rb_index,
      output fu_ready,
      output cdb_valid,
      output cdb_data,
      output cdb_addr,
      output cdb_rb_index,
      output cdb_fu
   );

endinterface

// File: rtl/cdb_lane_arbiter_rr_multi_grant.sv
// Combinational rotating-priority picker: selects up to CDB_LANES requesters
// starting at ptr and reports which FU landed on each lane.
module cdb_lane_arbiter_rr_multi_grant
   import cdb_lane_arbiter_pkg::*;
#(
   parameter int FU_NUM    = DEF_FU_NUM,
   parameter int CDB_LANES = DEF_CDB_LANES,
   localparam int FU_INDEX = $clog2(FU_NUM)
)(
   input  logic [FU_NUM-1:0]           req,
   input  logic [FU_INDEX-1:0]         ptr,
   output logic [FU_NUM-1:0]           grant,
   output logic [CDB_LANES-1:0]        lane_valid,
   output logic [CDB_LANES*FU_INDEX-1:0] lane_idx,
   output logic [CDB_LANES*FU_NUM-1:0] lane_onehot,
   output logic [FU_INDEX-1:0]         last_idx,
   output logic                        any_grant
);

   int pos  [FU_NUM];
   int rank [FU_NUM];
   int best_pos;

   // Rank every requester by how many requesters precede it in rotated order;
   // the first CDB_LANES ranks win, rank k drives lane k.
   always_comb begin
      grant       = '0;
      lane_valid  = '0;
      lane_idx    = '0;
      lane_onehot = '0;
      last_idx    = '0;
      any_grant   = 1'b0;
      best_pos    = -1;
      for (int i = 0; i < FU_NUM; i++) begin
         pos[i] = rotate_pos(i, int'(ptr), FU_NUM);
      end
      for (int i = 0; i < FU_NUM; i++) begin
         rank[i] = 0;
         for (int j = 0; j < FU_NUM; j++) begin
            if (req[j] && (pos[j] < pos[i])) begin
               rank[i] = rank[i] + 1;
            end
         end
      end
      for (int i = 0; i < FU_NUM; i++) begin
         if (req[i] && (rank[i] < CDB_LANES)) begin
            grant[i]  = 1'b1;
            any_grant = 1'b1;
            if (pos[i] > best_pos) begin
               best_pos = pos[i];
               last_idx = FU_INDEX'(i);
            end
            for (int k = 0; k < CDB_LANES; k++) begin
               if (rank[i] == k) begin
                  lane_valid[k]                         = 1'b1;
                  lane_idx[k*FU_INDEX +: FU_INDEX]      = FU_INDEX'(i);
                  lane_onehot[k*FU_NUM + i]             = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/cdb_lane_arbiter.sv
// Multi-lane common data bus arbiter: one-entry hold slot per FU, rotating
// priority across FUs, up to CDB_LANES registered broadcasts per cycle.
module cdb_lane_arbiter
   import cdb_lane_arbiter_pkg::*;
#(
   parameter int WORD_SIZE = DEF_WORD_SIZE,
   parameter int RB_INDEX  = DEF_RB_INDEX,
   parameter int FU_NUM    = DEF_FU_NUM,
   parameter int CDB_LANES = DEF_CDB_LANES
)(
   input  logic clk,
   input  logic reset,
   input  logic flush,
   cdb_lane_arbiter_if.slave bus
);

   localparam int FU_INDEX = $clog2(FU_NUM);

   logic [FU_NUM-1:0]    hold_v;
   logic [WORD_SIZE-1:0] hold_data [FU_NUM];
   logic [WORD_SIZE-1:0] hold_addr [FU_NUM];
   logic [RB_INDEX-1:0]  hold_rb   [FU_NUM];
   logic [FU_INDEX-1:0]  rr_ptr;

   logic [FU_NUM-1:0]             grant;
   logic [FU_NUM-1:0]             accept;
   logic [CDB_LANES-1:0]          lane_valid;
   logic [CDB_LANES*FU_INDEX-1:0] lane_idx;
   logic [CDB_LANES*FU_NUM-1:0]   lane_onehot;
   logic [FU_INDEX-1:0]           last_idx;
   logic                          any_grant;

   logic [CDB_LANES*WORD_SIZE-1:0] cdb_data_n;
   logic [CDB_LANES*WORD_SIZE-1:0] cdb_addr_n;
   logic [CDB_LANES*RB_INDEX-1:0]  cdb_rb_n;

   logic [CDB_LANES-1:0]           cdb_valid_r;
   logic [CDB_LANES*WORD_SIZE-1:0] cdb_data_r;
   logic [CDB_LANES*WORD_SIZE-1:0] cdb_addr_r;
   logic [CDB_LANES*RB_INDEX-1:0]  cdb_rb_r;
   logic [CDB_LANES*FU_INDEX-1:0]  cdb_fu_r;

   cdb_lane_arbiter_rr_multi_grant #(
      .FU_NUM    (FU_NUM),
      .CDB_LANES (CDB_LANES)
   ) u_grant (
      .req         (hold_v),
      .ptr         (rr_ptr),
      .grant       (grant),
      .lane_valid  (lane_valid),
      .lane_idx    (lane_idx),
      .lane_onehot (lane_onehot),
      .last_idx    (last_idx),
      .any_grant   (any_grant)
   );

   // A slot being drained this cycle can refill on the same edge, so ready
   // depends only on registered state and never on fu_valid.
   assign bus.fu_ready = ~hold_v | grant;
   assign accept       = bus.fu_valid & bus.fu_ready;

   // Route each lane's selected hold slot onto its next-cycle payload; idle lanes stay zero.
   always_comb begin
      cdb_data_n = '0;
      cdb_addr_n = '0;
      cdb_rb_n   = '0;
      for (int k = 0; k < CDB_LANES; k++) begin
         for (int i = 0; i < FU_NUM; i++) begin
            if (lane_onehot[k*FU_NUM + i]) begin
               cdb_data_n[k*WORD_SIZE +: WORD_SIZE] = hold_data[i];
               cdb_addr_n[k*WORD_SIZE +: WORD_SIZE] = hold_addr[i];
               cdb_rb_n[k*RB_INDEX +: RB_INDEX]     = hold_rb[i];
            end
         end
      end
   end

   // Hold slots: capture on handshake, empty when granted, squash everything on flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_v <= '0;
         for (int i = 0; i < FU_NUM; i++) begin
            hold_data[i] <= '0;
            hold_addr[i] <= '0;
            hold_rb[i]   <= '0;
         end
      end else if (flush) begin
         hold_v <= '0;
      end else begin
         for (int i = 0; i < FU_NUM; i++) begin
            if (accept[i]) begin
               hold_v[i]    <= 1'b1;
               hold_data[i] <= bus.fu_data[i*WORD_SIZE +: WORD_SIZE];
               hold_addr[i] <= bus.fu_addr[i*WORD_SIZE +: WORD_SIZE];
               hold_rb[i]   <= bus.fu_rb_index[i*RB_INDEX +: RB_INDEX];
            end else if (grant[i]) begin
               hold_v[i] <= 1'b0;
            end
         end
      end
   end

   // Lane output registers: one-cycle pulse per granted result; a flush kills what was about to go out.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         cdb_valid_r <= '0;
         cdb_data_r  <= '0;
         cdb_addr_r  <= '0;
         cdb_rb_r    <= '0;
         cdb_fu_r    <= '0;
      end else begin
         cdb_valid_r <= lane_valid;
         cdb_data_r  <= cdb_data_n;
         cdb_addr_r  <= cdb_addr_n;
         cdb_rb_r    <= cdb_rb_n;
         cdb_fu_r    <= lane_idx;
      end
   end

   // Round-robin pointer moves just past the last FU served so nobody waits more than one lap.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rr_ptr <= '0;
      end else if (any_grant) begin
         rr_ptr <= FU_INDEX'(wrap_inc(int'(last_idx), FU_NUM));
      end
   end

   assign bus.cdb_valid    = cdb_valid_r;
   assign bus.cdb_data     = cdb_data_r;
   assign bus.cdb_addr     = cdb_addr_r;
   assign bus.cdb_rb_index = cdb_rb_r;
   assign bus.cdb_fu       = cdb_fu_r;

   // The picker must never exceed the lane count or grant an empty slot.
   grant_count_ok : assert property (@(posedge clk) disable iff (reset)
      $countones(grant) <= CDB_LANES);
   grant_only_full : assert property (@(posedge clk) disable iff (reset)
      (grant & ~hold_v) == '0);

endmodule

// File: tb/tb_cdb_lane_arbiter.sv
// Self-checking bench for cdb_lane_arbiter: a cycle model of hold slots and
// the rotating pointer pushes expected lane outputs into a scoreboard queue
// as stimulus is driven; each scenario task pops and compares them.
module tb_cdb_lane_arbiter;

   localparam int W  = 32;
   localparam int RB = 4;
   localparam int N  = 8;
   localparam int L  = 2;
   localparam int FI = 3;

   typedef struct packed {
      logic          v;
      logic [W-1:0]  d;
      logic [W-1:0]  a;
      logic [RB-1:0] rb;
      logic [FI-1:0] fu;
   } lane_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic flush = 1'b0;

   int checks = 0;
   int errors = 0;

   lane_t exp_q [$];
   logic [N-1:0]  m_hv;
   logic [W-1:0]  m_d  [N];
   logic [W-1:0]  m_a  [N];
   logic [RB-1:0] m_rb [N];
   int            m_ptr;
   int            seq;
   logic [N-1:0]  exp_ready;

   logic [W-1:0]  pat_d  [N];
   logic [W-1:0]  pat_a  [N];
   logic [RB-1:0] pat_rb [N];

   always #5 clk = ~clk;

   cdb_lane_arbiter_if #(.WORD_SIZE(W), .RB_INDEX(RB), .FU_NUM(N), .CDB_LANES(L)) bus ();

   cdb_lane_arbiter #(.WORD_SIZE(W), .RB_INDEX(RB), .FU_NUM(N), .CDB_LANES(L)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   // Fresh, distinguishable payloads for every FU on every cycle.
   task automatic gen_patterns();
      for (int i = 0; i < N; i++) begin
         pat_d[i]  = {16'(seq), 8'h5A, 8'(i)};
         pat_a[i]  = {8'(i), 24'(seq * 3 + 1)};
         pat_rb[i] = RB'(seq + i);
      end
   endtask

   // Called at a negedge: drive one cycle of stimulus, predict the lane outputs
   // that follow the next posedge and advance the reference model.
   task automatic drive_cycle(input logic [N-1:0] v, input logic fl);
      lane_t        lanes [L];
      logic [N-1:0] g;
      int           cnt;
      int           last;
      int           idx;
      g    = '0;
      cnt  = 0;
      last = 0;
      for (int k = 0; k < L; k++) lanes[k] = '0;
      for (int off = 0; off < N; off++) begin
         idx = (m_ptr + off) % N;
         if (m_hv[idx] && cnt < L) begin
            g[idx]     = 1'b1;
            lanes[cnt] = '{v: 1'b1, d: m_d[idx], a: m_a[idx], rb: m_rb[idx], fu: FI'(idx)};
            cnt++;
            last = idx;
         end
      end
      exp_ready    = ~m_hv | g;
      bus.fu_valid = v;
      flush        = fl;
      for (int i = 0; i < N; i++) begin
         bus.fu_data[i*W +: W]       = pat_d[i];
         bus.fu_addr[i*W +: W]       = pat_a[i];
         bus.fu_rb_index[i*RB +: RB] = pat_rb[i];
      end
      for (int k = 0; k < L; k++) exp_q.push_back(fl ? lane_t'('0) : lanes[k]);
      for (int i = 0; i < N; i++) begin
         if (fl) begin
            m_hv[i] = 1'b0;
         end else if (v[i] && exp_ready[i]) begin
            m_hv[i] = 1'b1;
            m_d[i]  = pat_d[i];
            m_a[i]  = pat_a[i];
            m_rb[i] = pat_rb[i];
         end else if (g[i]) begin
            m_hv[i] = 1'b0;
         end
      end
      if (fl) m_ptr = 0;
      else if (cnt > 0) m_ptr = (last + 1) % N;
      seq++;
   endtask

   task automatic apply_reset();
      reset        = 1'b1;
      flush        = 1'b0;
      bus.fu_valid = '1;
      bus.fu_data  = '0;
      bus.fu_addr  = '0;
      bus.fu_rb_index = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      m_hv  = '0;
      m_ptr = 0;
      seq   = 0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (bus.cdb_valid !== '0) begin
         errors++;
         $display("[TB] FAIL reset_cdb_valid: got %b want 00", bus.cdb_valid);
      end
      checks++;
      if (bus.fu_ready !== '1) begin
         errors++;
         $display("[TB] FAIL reset_fu_ready: got %b want 11111111", bus.fu_ready);
      end
      checks++;
      if ({bus.cdb_data, bus.cdb_addr, bus.cdb_rb_index, bus.cdb_fu} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_payload: got d=%h a=%h rb=%h fu=%h want all zero",
                  bus.cdb_data, bus.cdb_addr, bus.cdb_rb_index, bus.cdb_fu);
      end
      checks++;
      if (dut.rr_ptr !== 3'd0) begin
         errors++;
         $display("[TB] FAIL reset_rr_ptr: got %0d want 0", dut.rr_ptr);
      end
      bus.fu_valid = '0;
   endtask

   task automatic test_single();
      apply_reset();
      for (int c = 0; c < 3; c++) begin
         gen_patterns();
         pat_d[3]  = 32'h0000_1234;
         pat_rb[3] = 4'd5;
         drive_cycle((c == 0) ? 8'h08 : 8'h00, 1'b0);
         checks++;
         if (bus.fu_ready !== exp_ready) begin
            errors++;
            $display("[TB] FAIL single_ready cyc%0d: got %b want %b", c, bus.fu_ready, exp_ready);
         end
         @(posedge clk);
         @(negedge clk);
         for (int k = 0; k < L; k++) begin
            lane_t e;
            e = exp_q.pop_front();
            checks++;
            if (bus.cdb_valid[k] !== e.v || bus.cdb_data[k*W +: W] !== e.d || bus.cdb_addr[k*W +: W] !== e.a ||
                bus.cdb_rb_index[k*RB +: RB] !== e.rb || bus.cdb_fu[k*FI +: FI] !== e.fu) begin
               errors++;
               $display("[TB] FAIL single_lane%0d cyc%0d: got v=%b fu=%0d rb=%h d=%h a=%h want v=%b fu=%0d rb=%h d=%h a=%h",
                        k, c, bus.cdb_valid[k], bus.cdb_fu[k*FI +: FI], bus.cdb_rb_index[k*RB +: RB],
                        bus.cdb_data[k*W +: W], bus.cdb_addr[k*W +: W], e.v, e.fu, e.rb, e.d, e.a);
            end
         end
         if (c == 0) begin
            checks++;
            if (bus.cdb_valid !== 2'b00) begin
               errors++;
               $display("[TB] FAIL single_no_bypass: got %b want 00", bus.cdb_valid);
            end
         end
         if (c == 1) begin
            checks++;
            if (bus.cdb_valid !== 2'b01 || bus.cdb_data[W-1:0] !== 32'h1234 ||
                bus.cdb_rb_index[RB-1:0] !== 4'd5 || bus.cdb_fu[FI-1:0] !== 3'd3) begin
               errors++;
               $display("[TB] FAIL single_fu3: got v=%b d=%h rb=%h fu=%0d want v=01 d=00001234 rb=5 fu=3",
                        bus.cdb_valid, bus.cdb_data[W-1:0], bus.cdb_rb_index[RB-1:0], bus.cdb_fu[FI-1:0]);
            end
         end
      end
   endtask

   task automatic test_saturation();
      int hs [N];
      apply_reset();
      for (int i = 0; i < N; i++) hs[i] = 0;
      for (int c = 0; c < 22; c++) begin
         gen_patterns();
         drive_cycle(8'hFF, 1'b0);
         checks++;
         if (bus.fu_ready !== exp_ready) begin
            errors++;
            $display("[TB] FAIL sat_ready cyc%0d: got %b want %b", c, bus.fu_ready, exp_ready);
         end
         if (c >= 2 && c < 18) begin
            for (int i = 0; i < N; i++) hs[i] += int'(bus.fu_valid[i] & bus.fu_ready[i]);
         end
         @(posedge clk);
         @(negedge clk);
         for (int k = 0; k < L; k++) begin
            lane_t e;
            e = exp_q.pop_front();
            checks++;
            if (bus.cdb_valid[k] !== e.v || bus.cdb_data[k*W +: W] !== e.d || bus.cdb_addr[k*W +: W] !== e.a ||
                bus.cdb_rb_index[k*RB +: RB] !== e.rb || bus.cdb_fu[k*FI +: FI] !== e.fu) begin
               errors++;
               $display("[TB] FAIL sat_lane%0d cyc%0d: got v=%b fu=%0d rb=%h d=%h a=%h want v=%b fu=%0d rb=%h d=%h a=%h",
                        k, c, bus.cdb_valid[k], bus.cdb_fu[k*FI +: FI], bus.cdb_rb_index[k*RB +: RB],
                        bus.cdb_data[k*W +: W], bus.cdb_addr[k*W +: W], e.v, e.fu, e.rb, e.d, e.a);
            end
         end
         if (c >= 1) begin
            checks++;
            if (bus.cdb_valid !== 2'b11 || bus.cdb_fu[0 +: FI] !== FI'((2 * (c - 1)) % N) ||
                bus.cdb_fu[FI +: FI] !== FI'((2 * (c - 1) + 1) % N)) begin
               errors++;
               $display("[TB] FAIL sat_order cyc%0d: got v=%b fu0=%0d fu1=%0d want v=11 fu0=%0d fu1=%0d",
                        c, bus.cdb_valid, bus.cdb_fu[0 +: FI], bus.cdb_fu[FI +: FI],
                        (2 * (c - 1)) % N, (2 * (c - 1) + 1) % N);
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (hs[i] != 4) begin
            errors++;
            $display("[TB] FAIL sat_ack_rate fu%0d: got %0d acks in 16 cycles want 4", i, hs[i]);
         end
      end
      bus.fu_valid = '0;
   endtask

   task automatic test_wrap();
      logic [N-1:0] vs [6] = '{8'h40, 8'h81, 8'h00, 8'h07, 8'h00, 8'h00};
      apply_reset();
      for (int c = 0; c < 6; c++) begin
         gen_patterns();
         drive_cycle(vs[c], 1'b0);
         checks++;
         if (bus.fu_ready !== exp_ready) begin
            errors++;
            $display("[TB] FAIL wrap_ready cyc%0d: got %b want %b", c, bus.fu_ready, exp_ready);
         end
         @(posedge clk);
         @(negedge clk);
         for (int k = 0; k < L; k++) begin
            lane_t e;
            e = exp_q.pop_front();
            checks++;
            if (bus.cdb_valid[k] !== e.v || bus.cdb_data[k*W +: W] !== e.d || bus.cdb_addr[k*W +: W] !== e.a ||
                bus.cdb_rb_index[k*RB +: RB] !== e.rb || bus.cdb_fu[k*FI +: FI] !== e.fu) begin
               errors++;
               $display("[TB] FAIL wrap_lane%0d cyc%0d: got v=%b fu=%0d rb=%h d=%h a=%h want v=%b fu=%0d rb=%h d=%h a=%h",
                        k, c, bus.cdb_valid[k], bus.cdb_fu[k*FI +: FI], bus.cdb_rb_index[k*RB +: RB],
                        bus.cdb_data[k*W +: W], bus.cdb_addr[k*W +: W], e.v, e.fu, e.rb, e.d, e.a);
            end
         end
         if (c == 2) begin
            checks++;
            if (bus.cdb_valid !== 2'b11 || bus.cdb_fu[0 +: FI] !== 3'd7 || bus.cdb_fu[FI +: FI] !== 3'd0) begin
               errors++;
               $display("[TB] FAIL wrap_lanes: got v=%b fu0=%0d fu1=%0d want v=11 fu0=7 fu1=0",
                        bus.cdb_valid, bus.cdb_fu[0 +: FI], bus.cdb_fu[FI +: FI]);
            end
            checks++;
            if (dut.rr_ptr !== 3'd1) begin
               errors++;
               $display("[TB] FAIL wrap_rr_ptr: got %0d want 1", dut.rr_ptr);
            end
         end
      end
   endtask

   task automatic test_flush();
      logic [N-1:0] vs [6] = '{8'h1F, 8'hE0, 8'h00, 8'h00, 8'h00, 8'h00};
      apply_reset();
      for (int c = 0; c < 6; c++) begin
         gen_patterns();
         drive_cycle(vs[c], c == 1);
         checks++;
         if (bus.fu_ready !== exp_ready) begin
            errors++;
            $display("[TB] FAIL flush_ready cyc%0d: got %b want %b", c, bus.fu_ready, exp_ready);
         end
         @(posedge clk);
         @(negedge clk);
         for (int k = 0; k < L; k++) begin
            lane_t e;
            e = exp_q.pop_front();
            checks++;
            if (bus.cdb_valid[k] !== e.v || bus.cdb_data[k*W +: W] !== e.d || bus.cdb_addr[k*W +: W] !== e.a ||
                bus.cdb_rb_index[k*RB +: RB] !== e.rb || bus.cdb_fu[k*FI +: FI] !== e.fu) begin
               errors++;
               $display("[TB] FAIL flush_lane%0d cyc%0d: got v=%b fu=%0d rb=%h d=%h a=%h want v=%b fu=%0d rb=%h d=%h a=%h",
                        k, c, bus.cdb_valid[k], bus.cdb_fu[k*FI +: FI], bus.cdb_rb_index[k*RB +: RB],
                        bus.cdb_data[k*W +: W], bus.cdb_addr[k*W +: W], e.v, e.fu, e.rb, e.d, e.a);
            end
         end
         if (c == 1) begin
            checks++;
            if (bus.cdb_valid !== 2'b00 || bus.fu_ready !== 8'hFF || dut.rr_ptr !== 3'd0) begin
               errors++;
               $display("[TB] FAIL flush_state: got v=%b ready=%b ptr=%0d want v=00 ready=11111111 ptr=0",
                        bus.cdb_valid, bus.fu_ready, dut.rr_ptr);
            end
         end
      end
   endtask

   task automatic test_refill();
      apply_reset();
      for (int c = 0; c < 10; c++) begin
         gen_patterns();
         drive_cycle(8'h04, 1'b0);
         checks++;
         if (bus.fu_ready[2] !== 1'b1 || bus.fu_ready !== exp_ready) begin
            errors++;
            $display("[TB] FAIL refill_ready cyc%0d: got %b want %b", c, bus.fu_ready, exp_ready);
         end
         @(posedge clk);
         @(negedge clk);
         for (int k = 0; k < L; k++) begin
            lane_t e;
            e = exp_q.pop_front();
            checks++;
            if (bus.cdb_valid[k] !== e.v || bus.cdb_data[k*W +: W] !== e.d || bus.cdb_addr[k*W +: W] !== e.a ||
                bus.cdb_rb_index[k*RB +: RB] !== e.rb || bus.cdb_fu[k*FI +: FI] !== e.fu) begin
               errors++;
               $display("[TB] FAIL refill_lane%0d cyc%0d: got v=%b fu=%0d rb=%h d=%h a=%h want v=%b fu=%0d rb=%h d=%h a=%h",
                        k, c, bus.cdb_valid[k], bus.cdb_fu[k*FI +: FI], bus.cdb_rb_index[k*RB +: RB],
                        bus.cdb_data[k*W +: W], bus.cdb_addr[k*W +: W], e.v, e.fu, e.rb, e.d, e.a);
            end
         end
         if (c >= 1) begin
            checks++;
            if (bus.cdb_valid !== 2'b01 || bus.cdb_fu[0 +: FI] !== 3'd2) begin
               errors++;
               $display("[TB] FAIL refill_stream cyc%0d: got v=%b fu0=%0d want v=01 fu0=2",
                        c, bus.cdb_valid, bus.cdb_fu[0 +: FI]);
            end
         end
      end
      bus.fu_valid = '0;
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] v;
      logic         fl;
      apply_reset();
      for (int c = 0; c < 60; c++) begin
         gen_patterns();
         v  = N'($urandom);
         fl = ($urandom_range(0, 15) == 0);
         drive_cycle(v, fl);
         checks++;
         if (bus.fu_ready !== exp_ready) begin
            errors++;
            $display("[TB] FAIL b2b_ready cyc%0d: got %b want %b", c, bus.fu_ready, exp_ready);
         end
         @(posedge clk);
         @(negedge clk);
         for (int k = 0; k < L; k++) begin
            lane_t e;
            e = exp_q.pop_front();
            checks++;
            if (bus.cdb_valid[k] !== e.v || bus.cdb_data[k*W +: W] !== e.d || bus.cdb_addr[k*W +: W] !== e.a ||
                bus.cdb_rb_index[k*RB +: RB] !== e.rb || bus.cdb_fu[k*FI +: FI] !== e.fu) begin
               errors++;
               $display("[TB] FAIL b2b_lane%0d cyc%0d: got v=%b fu=%0d rb=%h d=%h a=%h want v=%b fu=%0d rb=%h d=%h a=%h",
                        k, c, bus.cdb_valid[k], bus.cdb_fu[k*FI +: FI], bus.cdb_rb_index[k*RB +: RB],
                        bus.cdb_data[k*W +: W], bus.cdb_addr[k*W +: W], e.v, e.fu, e.rb, e.d, e.a);
            end
         end
      end
      flush        = 1'b0;
      bus.fu_valid = '0;
   endtask

   // Guard against a stuck run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not reach its summary in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Scenario sequence.
   initial begin
      bus.fu_valid    = '0;
      bus.fu_data     = '0;
      bus.fu_addr     = '0;
      bus.fu_rb_index = '0;
      m_hv  = '0;
      m_ptr = 0;
      seq   = 0;
      test_reset();
      test_single();
      test_saturation();
      test_wrap();
      test_flush();
      test_refill();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
